seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter: the sending end for the team's serial sequence-detector Moore machines.
- Shifts a programmable PAT_W-bit pattern out MSB-first on a single-bit line, repeated a programmable number of times.
- Optional zero-filled gap between frames.
- Drives the detector's x1 input in the tt_um test harness and on the bench; default pattern 4'b1101.

Parameters:
- PAT_W, 4: pattern length in bits (2..16).
- CNT_W, 4: width of repeat count and frame counter.
- GAP_W, 3: width of the inter-frame gap length.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request transmission; sampled only in IDLE.
- abort  in  1  cancel an ongoing transmission.
- pattern  in  PAT_W  bits to send, MSB first; latched on accepted start.
- reps  in  CNT_W  number of frames to send; latched on accepted start.
- gap  in  GAP_W  zero bits inserted between frames; latched on accepted start.
- tx_bit  out  1  serial data bit (feeds detector x1).
- tx_valid  out  1  tx_bit is meaningful this cycle.
- busy  out  1  high in SEND or GAP.
- done  out  1  one-cycle pulse after the final frame.
- frame_cnt  out  CNT_W  frames completed since the last accepted start.
- state_o  out  2  state code for debug / uo_out mapping.

Behaviour:
- Reset:
  - rst has highest priority; it is sampled only at posedge clk.
  - After a reset edge: state IDLE, tx_bit=0, tx_valid=0, busy=0, done=0, frame_cnt=0, state_o=2'b00.
  - Latched pattern, reps and gap are cleared to 0.
  - Reset mid-transmission aborts immediately; no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- State codes: IDLE=00, SEND=01, GAP=10, DONE=11.
- IDLE:
  - tx_valid=0, tx_bit=0.
  - start=1 and abort=0 at edge k: latch inputs, clear frame_cnt, bit index=PAT_W-1.
    - If reps!=0, go to SEND.
    - If reps==0, go to DONE directly; no bits are sent.
  - start=1 with abort=1 in IDLE: abort wins, start is ignored, stay IDLE.
- SEND:
  - Each cycle: tx_valid=1, tx_bit=pattern[idx]; idx decrements.
  - First bit is visible in the cycle after edge k (latency 1).
  - After bit 0 is sent, frame_cnt increments (saturating is not needed; max value is reps).
  - If frame_cnt+1==reps, go to DONE.
  - Else if gap==0, reload idx and stay in SEND (back-to-back frames, no idle cycle).
  - Else go to GAP with gap counter = gap.
- GAP:
  - tx_valid=1, tx_bit=0 for exactly gap cycles.
  - Then go to SEND with idx reloaded.
- DONE:
  - One cycle: done=1, tx_valid=0, busy=0.
  - Next state IDLE. frame_cnt holds until the next accepted start.
- start while busy (SEND/GAP/DONE) is ignored; latched values are not disturbed.
- abort in SEND or GAP:
  - Next cycle state is IDLE, tx_valid=0, tx_bit=0, no done pulse.
  - frame_cnt holds its partial count.
- abort in DONE is ignored; done still pulses.
- Inputs pattern, reps and gap may change freely after an accepted start without effect.
- Total valid cycles = reps·PAT_W + (reps−1)·gap.
  - done is high in the cycle after the last valid bit.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding localparams (S_IDLE, S_SEND, S_GAP, S_DONE);
  - default pattern constant DET_PATTERN = 4'b1101;
  - default widths.
- The detector and this transmitter both import seq_pkg.
- One sub-module: pattern_shifter. It contains the PAT_W shift register plus bit counter, with load, shift and last outputs.
- The FSM, gap counter and frame counter stay in seq_pattern_tx.

Test Plan:
- Reset and idle: hold rst=1 for 3 cycles, then release with start=0 → all outputs 0, state_o=00 indefinitely.
- Back-to-back frames: pattern=1101, reps=2, gap=0, start at edge 0 →
  - tx_valid=1 in cycles 1–8, tx_bit=1,1,0,1,1,1,0,1;
  - done=1 in cycle 9 only;
  - frame_cnt=2.
  - The attached detector's z1 asserts twice.
- Gap between frames: pattern=1101, reps=2, gap=2 → tx_bit=1,1,0,1,0,0,1,1,0,1 in cycles 1–10; busy high 1–10; done in cycle 11.
- Zero repeats and ignored start: reps=0 start → done in cycle 1, tx_valid never high. A start pulse asserted mid-SEND has no effect on the bit stream.
- Abort: reps=3, abort asserted in cycle 6 → from cycle 7 state_o=00, tx_valid=0, done never pulses, frame_cnt=1. Abort+start together in IDLE → stays IDLE.
- Reset mid-frame: rst=1 in cycle 3 of SEND → all outputs at reset values from the next edge. A fresh start then transmits the full sequence correctly.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence-detector family: state codes,
// default widths and the reference pattern the detectors look for.
package seq_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_W_DEF = 3;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SEND = 2'b01;
  localparam logic [1:0] S_GAP  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam logic [PAT_W_DEF-1:0] DET_PATTERN = 4'b1101;

endpackage

// File: rtl/pattern_shifter.sv
// MSB-first shift register with a bit counter; load wins over shift.
// Single-cycle load/shift, no backpressure: the caller decides when to shift.
module pattern_shifter
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PAT_W-1:0] load_val,
  input  logic             shift,
  output logic             msb,
  output logic             last
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0] sr_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (load) begin
      sr_q  <= load_val;
      idx_q <= IDX_TOP;
    end else if (shift) begin
      sr_q  <= {sr_q[PAT_W-2:0], 1'b0};
      idx_q <= idx_q - 1'b1;
    end
  end

  assign msb  = sr_q[PAT_W-1];
  assign last = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: first bit one cycle after an accepted start,
// frames repeated with optional zero gaps; no backpressure, abort cancels.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [1:0]       state_o
);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] reps_q, cnt_q, cnt_inc;
  logic [GAP_W-1:0] gap_q, gap_cnt_q;

  logic             sh_load, sh_shift, sh_msb, sh_last;
  logic [PAT_W-1:0] sh_val;
  logic             latch, cnt_clr, cnt_step, gap_load, gap_dec;

  assign cnt_inc = cnt_q + CNT_W'(1);

  pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .load_val (sh_val),
    .shift    (sh_shift),
    .msb      (sh_msb),
    .last     (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sh_load  = 1'b0;
    sh_val   = pat_q;
    sh_shift = 1'b0;
    latch    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          latch   = 1'b1;
          cnt_clr = 1'b1;
          sh_load = 1'b1;
          sh_val  = pattern;
          state_d = (reps != '0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        // An abort on the last bit of a frame leaves the frame uncounted.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          sh_shift = 1'b1;
          if (sh_last) begin
            cnt_step = 1'b1;
            if (cnt_inc == reps_q) begin
              state_d = S_DONE;
            end else if (gap_q == '0) begin
              sh_load = 1'b1;
            end else begin
              gap_load = 1'b1;
              state_d  = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          sh_load = 1'b1;
          state_d = S_SEND;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (latch) begin
        pat_q  <= pattern;
        reps_q <= reps;
        gap_q  <= gap;
      end
      if (cnt_clr)       cnt_q <= '0;
      else if (cnt_step) cnt_q <= cnt_inc;
      if (gap_load)      gap_cnt_q <= gap_q;
      else if (gap_dec)  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

  always_comb begin
    tx_valid  = (state_q == S_SEND) || (state_q == S_GAP);
    tx_bit    = (state_q == S_SEND) && sh_msb;
    busy      = tx_valid;
    done      = (state_q == S_DONE);
    frame_cnt = cnt_q;
    state_o   = state_q;
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle expected outputs are queued
// from a frame model when a transfer is started and popped after each edge.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] pattern, reps;
  logic [2:0] gap;
  logic       tx_bit, tx_valid, busy, done;
  logic [3:0] frame_cnt;
  logic [1:0] state_o;

  typedef struct packed {
    logic       tx_bit;
    logic       tx_valid;
    logic       busy;
    logic       done;
    logic [3:0] frame_cnt;
    logic [1:0] state;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [3:0] win;
  int   det_hits;

  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .reps(reps), .gap(gap),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic b, input logic v, input logic d,
                              input logic [3:0] c, input logic [1:0] s);
    exp_t e;
    e.tx_bit = b; e.tx_valid = v; e.busy = v; e.done = d;
    e.frame_cnt = c; e.state = s;
    return e;
  endfunction

  // Reference frame model: bits MSB first, zero gaps, then DONE and one IDLE.
  task automatic push_frames(input logic [3:0] p, input int r, input int g);
    for (int f = 0; f < r; f++) begin
      for (int b = 3; b >= 0; b--) begin
        logic [3:0] pv;
        pv = p;
        q.push_back(mk(pv[b], 1'b1, 1'b0, 4'(f), 2'b01));
      end
      if (f < r - 1)
        for (int k = 0; k < g; k++) q.push_back(mk(1'b0, 1'b1, 1'b0, 4'(f + 1), 2'b10));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b1, 4'(r), 2'b11));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 4'(r), 2'b00));
  endtask

  task automatic step(input string tag);
    exp_t e, o;
    @(posedge clk);
    #1;
    cyc++;
    o = '{tx_bit, tx_valid, busy, done, frame_cnt, state_o};
    if (tx_valid) begin
      win = {win[2:0], tx_bit};
      if (win == 4'b1101) det_hits++;
    end
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s c%0d scoreboard underflow got=%h", tag, cyc, o);
    end else begin
      e = q.pop_front();
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s c%0d got=%h exp=%h", tag, cyc, o, e);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) step(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 4'b0; reps = 4'd0; gap = 3'd0;
    win = 4'b0; det_hits = 0;

    // Reset held three cycles, then idle stays quiet.
    for (int i = 0; i < 3; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00));
    drain("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00));
    drain("idle");

    // Back-to-back frames; inputs scrambled after start must not matter.
    pattern = 4'b1101; reps = 4'd2; gap = 3'd0; start = 1'b1;
    push_frames(4'b1101, 2, 0);
    win = 4'b0; det_hits = 0;
    step("b2b");
    start = 1'b0; pattern = 4'b0000; reps = 4'd7; gap = 3'd5;
    drain("b2b");
    total++;
    assert (det_hits === 2) else begin
      bad++;
      $error("FAIL det_hits got=%0d exp=2", det_hits);
    end

    // Gap of two zero bits between frames.
    pattern = 4'b1101; reps = 4'd2; gap = 3'd2; start = 1'b1;
    push_frames(4'b1101, 2, 2);
    step("gap");
    start = 1'b0;
    drain("gap");

    // Zero repeats goes straight to DONE.
    reps = 4'd0; start = 1'b1;
    push_frames(4'b1101, 0, 0);
    step("reps0");
    start = 1'b0;
    drain("reps0");

    // Start pulse while sending is ignored.
    pattern = 4'b1011; reps = 4'd1; gap = 3'd0; start = 1'b1;
    push_frames(4'b1011, 1, 0);
    step("busy_start");
    start = 1'b0;
    step("busy_start");
    start = 1'b1; pattern = 4'b0000; reps = 4'd5;
    step("busy_start");
    start = 1'b0;
    drain("busy_start");

    // Abort during cycle 6 of a three-frame run.
    pattern = 4'b1101; reps = 4'd3; gap = 3'd0; start = 1'b1;
    push_frames(4'b1101, 3, 0);
    q = q[0:5];
    for (int i = 0; i < 3; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd1, 2'b00));
    step("abort");
    start = 1'b0;
    for (int i = 0; i < 5; i++) step("abort");
    abort = 1'b1;
    step("abort");
    abort = 1'b0;
    drain("abort");

    // Abort together with start in IDLE keeps IDLE and the old count.
    start = 1'b1; abort = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd1, 2'b00));
    step("abort_start");
    start = 1'b0; abort = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd1, 2'b00));
    drain("abort_start");

    // Reset in cycle 3 of SEND, then a fresh full transfer.
    pattern = 4'b1101; reps = 4'd2; gap = 3'd0; start = 1'b1;
    push_frames(4'b1101, 2, 0);
    q = q[0:2];
    step("rst_mid");
    start = 1'b0;
    step("rst_mid");
    step("rst_mid");
    rst = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00));
    step("rst_mid");
    rst = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'b00));
    drain("rst_mid");

    pattern = 4'b1001; reps = 4'd3; gap = 3'd1; start = 1'b1;
    push_frames(4'b1001, 3, 1);
    step("fresh");
    start = 1'b0;
    drain("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
